seg_scan_capture: RTL and testbench
===================================

# seg_scan_capture

Capture block for multiplexed seven-segment display buses. Samples the scanned segment lines and one-hot digit enables and waits for each pattern to be stable. Converts every stable pattern back to a BCD digit and publishes a complete, atomically updated multi-digit frame with per-digit error flags. It sits on the check side of a display path: it watches a scanned display driver and recovers the digit values it is showing, for self-check and for loopback testing of display logic.

## Interface
- DIGITS, 4, number of scanned digits (1..8)
- STABLE_CYCLES, 3, consecutive identical samples needed for a capture (2..15)

- clk  in  1  system clock, all logic on rising edge
- rst_n  in  1  asynchronous active-low reset
- seg_in  in  7  segment lines, common cathode, bit6=a … bit0=g, 1 = lit
- dig_en  in  DIGITS  digit enables, active-high, legal only when one-hot
- bcd_out  out  4*DIGITS  published digits, digit i at bits [4i+3:4i]
- err_out  out  DIGITS  published per-digit invalid-pattern flags
- frame_err  out  1  OR of err_out, updated with bcd_out
- frame_valid  out  1  one-cycle pulse when bcd_out/err_out are republished

## Operation
- Sample register s_reg holds the previous {seg_in, dig_en}. It is loaded every cycle.
- Run counter run_cnt, saturating at STABLE_CYCLES.
  - If the current {seg_in, dig_en} equals s_reg: run_cnt <= min(run_cnt+1, STABLE_CYCLES).
  - Otherwise: run_cnt <= 1.
- Capture event: the edge where run_cnt goes from STABLE_CYCLES-1 to STABLE_CYCLES, and the current dig_en is one-hot.
  - Exactly one capture per stable run. A run longer than STABLE_CYCLES does not recapture.
  - A zero or multi-hot dig_en never captures. The counter still runs as normal.
- Decode on capture, for the enabled digit i:
  - 1111110→0, 0110000→1, 1101101→2, 1111001→3, 0110011→4, 1011011→5, 1011111→6, 1110000→7, 1111111→8, 1111011→9.
  - Any other pattern → value 0 with the error bit set.
  - The value and error bit are written to shadow slot i, and seen[i] is set.
- Recapturing digit i before the frame completes overwrites shadow slot i. seen is unchanged.
- Frame completion: when a capture makes seen all-ones, the block does all of the following on that same edge:
  - Copies every shadow slot, including the slot being captured now, into bcd_out/err_out.
  - Sets frame_err = |err.
  - Pulses frame_valid.
  - Clears seen to 0.
- Published outputs hold their values between frames. Partial frames are never visible.
- Scan order is free. Digits may arrive in any order and with repeats.

## Timing
- Reset (asynchronous, rst_n low):
  - Registers cleared: s_reg, run_cnt, shadow slots, seen, bcd_out, err_out, frame_err and frame_valid all go to 0.
  - Reset in mid-frame discards the partial frame. Capture restarts from an empty seen after release.
- Latency: an input first sampled at edge k and held constant captures at edge k+STABLE_CYCLES-1. If it completes a frame, bcd_out and frame_valid update at that same edge.
- frame_valid is high for exactly one cycle per completed frame. Back-to-back frames give separate pulses.
- The inputs are treated as synchronous to clk. Any synchronisation is done upstream.
- A single-cycle glitch resets run_cnt to 1. A glitch therefore delays capture but never produces one, because STABLE_CYCLES >= 2.

## Test plan
- Basic frame, DIGITS=4, STABLE_CYCLES=3:
  - Stimulus: scan digits 0..3 with patterns 1111001, 0110000, 1011011, 1110000, each held 4 cycles.
  - Required: one frame_valid pulse at the 3rd stable edge of digit 3, bcd_out=16'h7513, err_out=0, frame_err=0.
- Invalid pattern:
  - Stimulus: digit 2 shows 0000001; the other digits are valid.
  - Required: bcd_out[11:8]=0, err_out=4'b0100, frame_err=1.
- Stability filter:
  - Stimulus: digit 0 held only 2 cycles, then dig_en changes.
  - Required: no capture and no frame_valid. Holding it 3 cycles captures once; holding it 10 cycles still captures once.
- Illegal enables:
  - Stimulus: dig_en=0000 and dig_en=0011, each held 8 cycles.
  - Required: seen is unchanged and no frame_valid pulse occurs.
- Overwrite and atomicity:
  - Stimulus: digit 1 shows 4, then 9 before digit 3 is captured.
  - Required: bcd_out is unchanged until completion, then digit 1 reads 9.
- Reset mid-frame:
  - Stimulus: capture digits 0–2, pulse rst_n low, then scan digit 3 only.
  - Required: all outputs are 0 during reset, and there is no frame_valid until all 4 digits are recaptured.

Source files
------------

// File: rtl/seg_scan_capture.sv
// Purpose : recover BCD digits from a scanned 7-segment bus and publish complete frames with per-digit error flags.
// Latency : a pattern held from edge k captures at edge k+STABLE_CYCLES-1; a completing capture publishes on that same edge.
// Backpr. : none; this block only observes the bus and can never stall it. frame_valid pulses once per frame.
// Ports   : clk, rst_n (async, active-low); seg_in[6:0] (bit6=a .. bit0=g, 1 = lit); dig_en (one-hot digit enable);
//           bcd_out (digit i at [4i+3:4i]), err_out (per-digit invalid flag), frame_err (|err_out), frame_valid.
module seg_scan_capture #(
  parameter int DIGITS        = 4,
  parameter int STABLE_CYCLES = 3
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [6:0]            seg_in,
  input  logic [DIGITS-1:0]     dig_en,
  output logic [4*DIGITS-1:0]   bcd_out,
  output logic [DIGITS-1:0]     err_out,
  output logic                  frame_err,
  output logic                  frame_valid
);

  localparam int         SW      = 7 + DIGITS;
  localparam logic [3:0] RUN_MAX = 4'(STABLE_CYCLES);
  localparam logic [3:0] RUN_ARM = 4'(STABLE_CYCLES - 1);

  logic [SW-1:0]       s_reg;
  logic [3:0]          run_cnt;
  logic [4*DIGITS-1:0] shadow_bcd;
  logic [DIGITS-1:0]   shadow_err;
  logic [DIGITS-1:0]   seen;

  logic [SW-1:0]       sample;
  logic                same;
  logic                en_onehot;
  logic                capture;
  logic                complete;
  logic [3:0]          dec_val;
  logic                dec_err;
  logic [4*DIGITS-1:0] next_bcd;
  logic [DIGITS-1:0]   next_err;

  assign sample    = {seg_in, dig_en};
  assign same      = (sample == s_reg);
  assign en_onehot = (dig_en != '0) && ((dig_en & (dig_en - 1'b1)) == '0);

  // The arm level is only reached once per run because run_cnt saturates at
  // RUN_MAX, so a long hold cannot recapture.
  assign capture   = same && (run_cnt == RUN_ARM) && en_onehot;

  // dig_en is one-hot whenever capture is true, so OR-ing it into seen is
  // the post-capture seen set.
  assign complete  = capture && (&(seen | dig_en));

  always_comb begin
    dec_val = 4'd0;
    dec_err = 1'b0;
    case (seg_in)
      7'b1111110: dec_val = 4'd0;
      7'b0110000: dec_val = 4'd1;
      7'b1101101: dec_val = 4'd2;
      7'b1111001: dec_val = 4'd3;
      7'b0110011: dec_val = 4'd4;
      7'b1011011: dec_val = 4'd5;
      7'b1011111: dec_val = 4'd6;
      7'b1110000: dec_val = 4'd7;
      7'b1111111: dec_val = 4'd8;
      7'b1111011: dec_val = 4'd9;
      default:    dec_err = 1'b1;
    endcase
  end

  // Shadow contents as they will be after this edge's capture; used both to
  // update the shadow and to publish a completing frame in the same cycle.
  always_comb begin
    next_bcd = shadow_bcd;
    next_err = shadow_err;
    for (int i = 0; i < DIGITS; i++) begin
      if (dig_en[i]) begin
        next_bcd[4*i +: 4] = dec_val;
        next_err[i]        = dec_err;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s_reg       <= '0;
      run_cnt     <= '0;
      shadow_bcd  <= '0;
      shadow_err  <= '0;
      seen        <= '0;
      bcd_out     <= '0;
      err_out     <= '0;
      frame_err   <= 1'b0;
      frame_valid <= 1'b0;
    end else begin
      s_reg       <= sample;
      frame_valid <= 1'b0;

      if (!same)
        run_cnt <= 4'd1;
      else if (run_cnt != RUN_MAX)
        run_cnt <= run_cnt + 4'd1;

      if (capture) begin
        shadow_bcd <= next_bcd;
        shadow_err <= next_err;
        if (complete) begin
          bcd_out     <= next_bcd;
          err_out     <= next_err;
          frame_err   <= |next_err;
          frame_valid <= 1'b1;
          seen        <= '0;
        end else begin
          seen <= seen | dig_en;
        end
      end
    end
  end

endmodule

// File: tb/tb_seg_scan_capture.sv
// Purpose : self-checking bench for seg_scan_capture against a cycle-level reference of the capture rules.
// Latency : outputs compared 1 time unit after every rising edge against the reference model.
// Backpr. : not applicable; the bench drives the scan bus freely.
module tb_seg_scan_capture;

  localparam int DG = 4;
  localparam int SC = 3;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic [6:0]        seg_in = '0;
  logic [DG-1:0]     dig_en = '0;
  logic [4*DG-1:0]   bcd_out;
  logic [DG-1:0]     err_out;
  logic              frame_err;
  logic              frame_valid;

  seg_scan_capture #(.DIGITS(DG), .STABLE_CYCLES(SC)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .seg_in      (seg_in),
    .dig_en      (dig_en),
    .bcd_out     (bcd_out),
    .err_out     (err_out),
    .frame_err   (frame_err),
    .frame_valid (frame_valid)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;

  logic [6:0] pat [10] = '{7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001, 7'b0110011,
                           7'b1011011, 7'b1011111, 7'b1110000, 7'b1111111, 7'b1111011};

  // Reference model state: length of the current run of identical samples,
  // per-digit shadow values, the set of digits seen, and published outputs.
  logic [6+DG:0]   m_prev;
  int              m_run;
  logic [3:0]      m_sh_val [DG];
  logic            m_sh_err [DG];
  logic [DG-1:0]   m_seen;
  logic [4*DG-1:0] m_bcd;
  logic [DG-1:0]   m_err;
  logic            m_ferr;
  logic            m_fv;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
  endtask

  task automatic model_reset();
    m_prev = '0;
    m_run  = 0;
    m_seen = '0;
    m_bcd  = '0;
    m_err  = '0;
    m_ferr = 1'b0;
    m_fv   = 1'b0;
    for (int i = 0; i < DG; i++) begin
      m_sh_val[i] = '0;
      m_sh_err[i] = 1'b0;
    end
  endtask

  task automatic model_edge(input logic [6:0] seg, input logic [DG-1:0] en);
    logic [6+DG:0] x;
    logic [3:0]    val;
    logic          err;
    x = {seg, en};
    if (x == m_prev) m_run = (m_run < 1000) ? m_run + 1 : m_run;
    else             m_run = 1;
    m_prev = x;
    m_fv   = 1'b0;
    // The SC-th identical sample in a row with a single enabled digit captures.
    if (m_run == SC && $countones(en) == 1) begin
      val = 4'd0;
      err = 1'b1;
      for (int k = 0; k < 10; k++) begin
        if (pat[k] == seg) begin
          val = 4'(k);
          err = 1'b0;
        end
      end
      for (int i = 0; i < DG; i++) begin
        if (en[i]) begin
          m_sh_val[i] = val;
          m_sh_err[i] = err;
          m_seen[i]   = 1'b1;
        end
      end
      if (&m_seen) begin
        for (int i = 0; i < DG; i++) begin
          m_bcd[4*i +: 4] = m_sh_val[i];
          m_err[i]        = m_sh_err[i];
        end
        m_ferr = |m_err;
        m_fv   = 1'b1;
        m_seen = '0;
      end
    end
  endtask

  task automatic check_outputs();
    check("frame_valid", 32'(frame_valid), 32'(m_fv));
    check("bcd_out",     32'(bcd_out),     32'(m_bcd));
    check("err_out",     32'(err_out),     32'(m_err));
    check("frame_err",   32'(frame_err),   32'(m_ferr));
  endtask

  task automatic step(input logic [6:0] seg, input logic [DG-1:0] en);
    seg_in = seg;
    dig_en = en;
    @(posedge clk);
    model_edge(seg, en);
    #1;
    check_outputs();
  endtask

  task automatic hold(input logic [6:0] seg, input logic [DG-1:0] en, input int n);
    for (int c = 0; c < n; c++) step(seg, en);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    model_reset();
    #1;
    check_outputs();
    repeat (2) @(posedge clk);
    #1;
    check_outputs();
    rst_n = 1'b1;
  endtask

  initial begin
    model_reset();
    do_reset();

    // Basic frame: digits 3,1,5,7 on positions 0..3.
    hold(pat[3], 4'b0001, 4);
    hold(pat[1], 4'b0010, 4);
    hold(pat[5], 4'b0100, 4);
    hold(pat[7], 4'b1000, 4);
    check("basic_bcd", 32'(bcd_out), 32'h7513);
    check("basic_err", 32'(err_out), 32'h0);

    // Invalid pattern on digit 2.
    hold(pat[2],     4'b0001, 4);
    hold(pat[6],     4'b0010, 4);
    hold(7'b0000001, 4'b0100, 4);
    hold(pat[9],     4'b1000, 4);
    check("inv_bcd",  32'(bcd_out),   32'h9062);
    check("inv_err",  32'(err_out),   32'b0100);
    check("inv_ferr", 32'(frame_err), 32'h1);

    // Stability filter: short hold, exact hold, long hold.
    hold(pat[4], 4'b0001, 2);
    hold(pat[4], 4'b0010, 3);
    hold(pat[8], 4'b0100, 10);

    // Illegal enables.
    hold(pat[8], 4'b0000, 8);
    hold(pat[8], 4'b0011, 8);

    // Overwrite and atomicity from an empty frame.
    do_reset();
    hold(pat[1], 4'b0001, 4);
    hold(pat[4], 4'b0010, 4);
    hold(pat[2], 4'b0100, 4);
    hold(pat[9], 4'b0010, 4);
    check("ovw_hold", 32'(bcd_out), 32'h0);
    hold(pat[5], 4'b1000, 4);
    check("ovw_bcd", 32'(bcd_out), 32'h5291);

    // Reset mid-frame, then digit 3 alone must not complete a frame.
    hold(pat[0], 4'b0001, 4);
    hold(pat[6], 4'b0010, 4);
    hold(pat[3], 4'b0100, 4);
    do_reset();
    hold(pat[7], 4'b1000, 4);
    check("rst_bcd", 32'(bcd_out), 32'h0);
    hold(pat[0], 4'b0001, 4);
    hold(pat[6], 4'b0010, 4);
    hold(pat[3], 4'b0100, 4);
    check("rst_done", 32'(bcd_out), 32'h7360);

    // Randomized scanning with glitches, illegal enables and repeats.
    for (int s = 0; s < 500; s++) begin
      logic [6:0]    seg;
      logic [DG-1:0] en;
      int            r;
      r   = int'($urandom_range(0, 99));
      seg = (r < 80) ? pat[$urandom_range(0, 9)] : 7'($urandom);
      en  = (r % 7 == 0) ? DG'($urandom) : DG'(1 << $urandom_range(0, DG - 1));
      if (r == 50) do_reset();
      hold(seg, en, int'($urandom_range(1, 6)));
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
